// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory request/response bus.
//   imem_req   - request valid (driven by the sequencer)
//   imem_addr  - word address of the request, held until acked
//   imem_ack   - response strobe; imem_rdata is valid in the same cycle
//   imem_rdata - fetched instruction word
// master = fetch sequencer, slave = instruction memory.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: single-outstanding instruction fetch stage.
// Issues one memory request at a time, holds the returned word for the
// decoder until it is accepted, and handles branch/jump redirects arriving
// at any point, including while a request is still in flight.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   PCSrc/PCTarget - redirect request and its target address
//   imem           - instruction-memory bus (master side)
//   Instr/PC       - held instruction and its address
//   instr_valid    - Instr/PC valid; instr_ready - consumer accepts
//   fetch_count    - number of completed instr_valid & instr_ready cycles
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     PCSrc,
  input  logic [31:0]              PCTarget,
  fetch_sequencer_if.master        imem,
  output logic [31:0]              Instr,
  output logic [31:0]              PC,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [31:0]              fetch_count
);

  // FETCH: request outstanding; VALID: word held for decode;
  // FLUSH: request outstanding whose data must be thrown away.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;

  logic [31:0] target;
  logic        handshake;

  // Redirect targets are word aligned regardless of the low bits supplied.
  assign target    = {PCTarget[31:2], 2'b00};
  assign handshake = (state_q == VALID) && instr_ready;

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path can infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    count_d = count_q;

    // A handshake still counts when a redirect lands in the same cycle.
    if (handshake) count_d = count_q + 32'd1;

    // Redirect always owns the next PC, whatever the state.
    if (PCSrc) pc_d = target;

    case (state_q)
      FETCH: begin
        if (imem.imem_ack) begin
          if (PCSrc) begin
            // Response belongs to the old path: drop it, relaunch at target.
            addr_d = target;
          end else begin
            instr_d = imem.imem_rdata;
            state_d = VALID;
          end
        end else if (PCSrc) begin
          // Address must stay put until the in-flight request is acked.
          state_d = FLUSH;
        end
      end
      VALID: begin
        if (PCSrc) begin
          addr_d  = target;
          state_d = FETCH;
        end else if (instr_ready) begin
          pc_d    = pc_q + 32'd4;
          addr_d  = pc_q + 32'd4;
          state_d = FETCH;
        end
      end
      FLUSH: begin
        if (imem.imem_ack) begin
          // Relaunch at the newest target, including one arriving right now.
          addr_d  = PCSrc ? target : pc_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: nonblocking assignments so every register updates from pre-edge values.
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      instr_q <= 32'h0000_0000;
      count_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  // Request is gated by reset directly so it is low for the whole reset
  // window and rises in the first cycle after release.
  assign imem.imem_req  = (state_q != VALID) && !reset;
  assign imem.imem_addr = addr_q;
  assign instr_valid    = (state_q == VALID);
  assign Instr          = instr_q;
  assign PC             = pc_q;
  assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer. Two instances share stimulus:
// u_dut0 starts at 0 and is scoreboarded, u_dut1 starts at 0xFFFF_FFFC to
// exercise sequential PC wrap.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcsrc;
  logic        ready;
  logic        ack;
  logic [31:0] tgt;

  always #5 clk = ~clk;

  fetch_sequencer_if m0 ();
  fetch_sequencer_if m1 ();

  // Memory model: deterministic word derived from the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign m0.imem_ack   = ack;
  assign m0.imem_rdata = mem_word(m0.imem_addr);
  assign m1.imem_ack   = ack;
  assign m1.imem_rdata = mem_word(m1.imem_addr);

  logic [31:0] instr0, pc0, count0;
  logic [31:0] instr1, pc1, count1;
  logic        valid0, valid1;

  fetch_sequencer #(.RESET_PC(32'h0000_0000)) u_dut0 (
    .clk         (clk),
    .reset       (reset),
    .PCSrc       (pcsrc),
    .PCTarget    (tgt),
    .imem        (m0.master),
    .Instr       (instr0),
    .PC          (pc0),
    .instr_valid (valid0),
    .instr_ready (ready),
    .fetch_count (count0)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) u_dut1 (
    .clk         (clk),
    .reset       (reset),
    .PCSrc       (pcsrc),
    .PCTarget    (tgt),
    .imem        (m1.master),
    .Instr       (instr1),
    .PC          (pc1),
    .instr_valid (valid1),
    .instr_ready (ready),
    .fetch_count (count1)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_fetch(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem_word(pc);
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs at the falling edge; if u_dut0 will complete
  // a handshake on the coming rising edge, pop and compare the scoreboard.
  task automatic cyc(input logic a, input logic r, input logic s, input logic [31:0] t);
    exp_t e;
    ack = a; ready = r; pcsrc = s; tgt = t;
    #1;
    if (valid0 && ready) begin
      exp_count++;
      check("sb_nonempty", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("hs_pc", pc0, e.pc);
        check("hs_instr", instr0, e.instr);
      end
    end
    @(negedge clk);
  endtask

  task automatic check_reset_state();
    check("rst_pc",     pc0,          32'h0);
    check("rst_addr",   m0.imem_addr, 32'h0);
    check("rst_req",    m0.imem_req,  0);
    check("rst_valid",  valid0,       0);
    check("rst_instr",  instr0,       32'h0);
    check("rst_count",  count0,       32'h0);
    check("rst_pc1",    pc1,          32'hFFFF_FFFC);
    check("rst_addr1",  m1.imem_addr, 32'hFFFF_FFFC);
  endtask

  initial begin
    reset = 1'b1; ack = 1'b0; ready = 1'b0; pcsrc = 1'b0; tgt = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check_reset_state();

    // Sequential stream, memory always acks, consumer always ready.
    reset = 1'b0;
    #1;
    check("req_after_reset", m0.imem_req, 1);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a0, a1;
      a0 = 32'h0 + 32'(4 * (i / 2));
      a1 = 32'hFFFF_FFFC + 32'(4 * (i / 2));
      if (i % 2 == 0) begin
        check("seq_req",   m0.imem_req,  1);
        check("seq_addr",  m0.imem_addr, a0);
        check("seq_valid", valid0,       0);
        check("wrap_addr", m1.imem_addr, a1);
        expect_fetch(a0);
      end else begin
        check("seq_valid_hi", valid0,      1);
        check("seq_req_lo",   m0.imem_req, 0);
        check("wrap_pc",      pc1,         a1);
        check("wrap_instr",   instr1,      mem_word(a1));
      end
      cyc(1'b1, 1'b1, 1'b0, 32'h0);
    end
    check("count_4", count0, 32'd4);

    // Consumer stalls: held word must not move and no request is issued.
    expect_fetch(32'h10);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", valid0,      1);
      check("stall_req",   m0.imem_req, 0);
      check("stall_pc",    pc0,         32'h10);
      check("stall_instr", instr0,      mem_word(32'h10));
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
    end
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("count_5", count0, 32'd5);

    // Redirect while a request is outstanding and unacked -> FLUSH.
    check("pre_flush_addr", m0.imem_addr, 32'h14);
    cyc(1'b0, 1'b0, 1'b1, 32'h0000_0103);
    check("flush_req",   m0.imem_req,  1);
    check("flush_addr",  m0.imem_addr, 32'h14);
    check("flush_pc",    pc0,          32'h100);
    check("flush_valid", valid0,       0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check("flush_hold_addr", m0.imem_addr, 32'h14);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("drop_valid", valid0,       0);
    check("drop_addr",  m0.imem_addr, 32'h100);
    check("drop_instr", instr0,       mem_word(32'h10));
    expect_fetch(32'h100);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("count_6", count0, 32'd6);

    // Handshake and redirect in the same cycle: counted, target wins.
    expect_fetch(32'h104);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 32'h0000_0400);
    check("hsredir_count", count0,       32'd7);
    check("hsredir_valid", valid0,       0);
    check("hsredir_addr",  m0.imem_addr, 32'h400);
    check("hsredir_pc",    pc0,          32'h400);
    expect_fetch(32'h400);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);

    // Redirect in FETCH with ack in the same cycle: data dropped, stay FETCH.
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_0802);
    check("fetchredir_valid", valid0,       0);
    check("fetchredir_req",   m0.imem_req,  1);
    check("fetchredir_addr",  m0.imem_addr, 32'h800);
    check("fetchredir_instr", instr0,       mem_word(32'h400));
    expect_fetch(32'h800);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("count_9", count0, 32'd9);

    // Reset while in FLUSH with a simultaneous ack.
    cyc(1'b0, 1'b0, 1'b1, 32'h0000_0900);
    check("flush2_addr", m0.imem_addr, 32'h804);
    reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 32'h0000_0A00);
    check_reset_state();
    exp_count = 0;
    reset = 1'b0;
    #1;
    check("post_rst_req",  m0.imem_req,  1);
    check("post_rst_addr", m0.imem_addr, 32'h0);
    expect_fetch(32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("post_rst_count", count0, 32'd1);

    check("sb_drain",    sb.size(), 0);
    check("count_model", count0,    32'(exp_count));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port PCSrc  input  1  redirect request from execute (taken branch or jump).
REQ-005 SHALL have port PCTarget  input  32  redirect address, valid when PCSrc=1.
REQ-006 SHALL have port imem_req  output  1  instruction-memory request.
REQ-007 SHALL have port imem_addr  output  32  request address, registered.
REQ-008 SHALL have port imem_ack  input  1  memory response; imem_rdata is valid in the same cycle.
REQ-009 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-010 SHALL have port Instr  output  32  held instruction to decode.
REQ-011 SHALL have port PC  output  32  address of Instr, or of the next fetch when instr_valid=0.
REQ-012 SHALL have port instr_valid  output  1  Instr/PC valid to the consumer.
REQ-013 SHALL have port instr_ready  input  1  consumer accepts Instr this cycle.
REQ-014 SHALL have port fetch_count  output  32  count of completed instr handshakes.

Function
REQ-015 SHALL implement three states: FETCH (request outstanding), VALID (instruction held), FLUSH (outstanding request whose data is discarded).
REQ-016 SHALL drive imem_req=1 in FETCH and FLUSH and 0 in VALID.
REQ-017 SHALL hold imem_addr stable from request launch until the cycle imem_ack=1.
REQ-018 SHALL accept imem_ack in the same cycle as imem_req (zero-wait memory); ack while imem_req=0 SHALL be ignored.
REQ-019 FETCH, imem_ack=1, PCSrc=0: SHALL latch imem_rdata into Instr and go to VALID.
REQ-020 VALID: SHALL assert instr_valid=1 and keep Instr/PC constant until the handshake or a redirect.
REQ-021 VALID, instr_ready=1, PCSrc=0: SHALL set PC<=PC+4 (mod 2^32), imem_addr<=PC+4, and go to FETCH.
REQ-022 The sequential PC SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000.
REQ-023 PCSrc=1 SHALL load PC<=PCTarget with bits [1:0] forced to 2'b00, in any state, overriding PC+4.
REQ-024 PCSrc=1 in VALID SHALL drop instr_valid the next cycle, set imem_addr<=target, and go to FETCH.
REQ-025 PCSrc=1 in FETCH with imem_ack=1 SHALL discard imem_rdata, set imem_addr<=target, and stay in FETCH.
REQ-026 PCSrc=1 in FETCH with imem_ack=0 SHALL go to FLUSH, keeping imem_addr unchanged.
REQ-027 FLUSH: SHALL discard the response and, on imem_ack=1, set imem_addr<=PC and go to FETCH.
REQ-028 PCSrc=1 in FLUSH SHALL update PC to the newest target and remain in FLUSH unless acked.
REQ-029 PCSrc=1 and instr_valid&instr_ready in the same cycle SHALL count as a completed handshake; the redirect SHALL still win for the next PC.
REQ-030 fetch_count SHALL increment by 1 per cycle with instr_valid&instr_ready=1, wrapping at 2^32.
REQ-031 instr_valid SHALL never be asserted in FETCH or FLUSH.
REQ-032 Steady-state throughput SHALL be one instruction per 2 cycles with zero-wait memory.

Reset
REQ-033 While reset=1: PC=RESET_PC, imem_addr=RESET_PC, imem_req=0, instr_valid=0, Instr=0, fetch_count=0, state=FETCH.
REQ-034 imem_req SHALL be forced to 0 during reset, and SHALL be 1 in the first cycle after reset deasserts.
REQ-035 Reset mid-request (FETCH or FLUSH) SHALL abandon the request; any ack in the reset cycle SHALL be ignored.
REQ-036 Reset SHALL take priority over PCSrc, imem_ack and instr_ready.

Verification
REQ-037 Reset release, ack every request, ready=1:
- expected: imem_addr 0,4,8,C on alternating cycles
- expected: Instr matches imem_rdata
- expected: fetch_count=4 after four handshakes.
REQ-038 VALID with ready=0 for 5 cycles:
- expected: Instr, PC and instr_valid held constant
- expected: imem_req=0 throughout.
REQ-039 FETCH, ack withheld, PCSrc=1 with PCTarget=32'h0000_0103:
- expected: state goes to FLUSH; imem_addr unchanged
- on ack: data dropped; next imem_addr=32'h0000_0100
- expected: the delivered instruction has PC=0x100.
REQ-040 VALID, PCSrc=1 and instr_ready=1 in the same cycle:
- expected: fetch_count increments
- expected: next fetch at the target, not PC+4.
REQ-041 RESET_PC=32'hFFFF_FFFC, two sequential handshakes:
- expected: second fetch at 32'h0000_0000.
REQ-042 Reset asserted during FLUSH with ack in the same cycle:
- expected: all outputs at reset values
- expected: first post-reset fetch at RESET_PC.
